// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator for the HDMI_CTRL path.
//
// Produces a pixel request stream (pixel_req, pixel_x, pixel_y) REQ_LEAD clocks ahead of the
// video timing outputs (h_sync, v_sync, pixel_de, rgb_out). That lead lets a frame-buffer FIFO
// be read ahead. Line and frame order is sync, back porch, active, front porch. Start and stop
// take effect only on frame boundaries: a frame that has begun always completes.
//
// Ports:
//   vga_clk     in   pixel clock, the only clock
//   rst_n       in   synchronous active-low reset
//   en          in   run request, acted on at frame boundaries
//   rgb_data    in   pixel data returned REQ_LEAD-1 clocks after its pixel_req
//   test_mode   in   (VGA_TIMING_TEST_PATTERN_EN only) select the 8-bar colour pattern
//   pixel_req   out  request for the active pixel at (pixel_x, pixel_y)
//   pixel_x     out  active-area column of the request (0 when no request)
//   pixel_y     out  active-area row of the request (0 when no request)
//   frame_start out  one-clock pulse at internal h=0, v=0 while running
//   running     out  high while counting (RUN or STOP_PEND)
//   h_sync      out  horizontal sync at HS_POL when asserted, REQ_LEAD clocks after request
//   v_sync      out  vertical sync at VS_POL when asserted, REQ_LEAD clocks after request
//   pixel_de    out  data enable, REQ_LEAD clocks after request
//   rgb_out     out  pixel output, 0 outside pixel_de
//
// Optional feature: define VGA_TIMING_TEST_PATTERN_EN to add the test_mode port and the
// colour-bar generator. Without it rgb_data is always the captured source.

module vga_timing_gen #(
  parameter int unsigned H_ACT    = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACT    = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned REQ_LEAD = 1,   // legal range 1..4
  parameter int unsigned CNT_W    = 12   // must hold H_TOTAL-1 and V_TOTAL-1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] rgb_data,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              pixel_req,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic              frame_start,
  output logic              running,
  output logic              h_sync,
  output logic              v_sync,
  output logic              pixel_de,
  output logic [DATA_W-1:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_DE_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_SYNC + V_BP + V_ACT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopPend
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  logic h_last, v_last;
  logic active;
  logic raw_hs, raw_vs, raw_de;

  // Delay chains. Tap 0 is the raw (undelayed) signal, tap i is delayed i clocks, so the
  // output stage is tap REQ_LEAD and the rgb capture enable is tap REQ_LEAD-1.
  logic [REQ_LEAD-1:0] hs_q, vs_q, de_q;
  logic [REQ_LEAD:0]   hs_tap, vs_tap, de_tap;

  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rgb_d, rgb_q;

  //--------------------------------------------------------------------------------------------
  // Control FSM and raster counters
  //--------------------------------------------------------------------------------------------
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;

    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (en) begin
          state_d = StRun;
        end
      end

      StRun, StStopPend: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + CNT_W'(1);
        end else begin
          h_d = h_q + CNT_W'(1);
        end

        if (state_q == StRun) begin
          // A stop request only arms the stop; the current frame runs to completion.
          if (!en) begin
            state_d = StStopPend;
          end
        end else if (en) begin
          state_d = StRun;
        end else if (h_last && v_last) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------------------------
  // Raw timing and request outputs; all derived from registers only
  //--------------------------------------------------------------------------------------------
  assign active = (state_q != StIdle);

  always_comb begin
    raw_hs = active && (h_q < H_SYNC_END);
    raw_vs = active && (v_q < V_SYNC_END);
    raw_de = active &&
             (h_q >= H_DE_BEG) && (h_q < H_DE_END) &&
             (v_q >= V_DE_BEG) && (v_q < V_DE_END);
  end

  assign pixel_req   = raw_de;
  assign pixel_x     = raw_de ? (h_q - H_DE_BEG) : '0;
  assign pixel_y     = raw_de ? (v_q - V_DE_BEG) : '0;
  assign frame_start = active && (h_q == '0) && (v_q == '0);
  assign running     = active;

  //--------------------------------------------------------------------------------------------
  // Alignment pipeline
  //--------------------------------------------------------------------------------------------
  assign hs_tap = {hs_q, raw_hs};
  assign vs_tap = {vs_q, raw_vs};
  assign de_tap = {de_q, raw_de};

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_DIV_I = (H_ACT / 8 == 0) ? 1 : H_ACT / 8;
  localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_DIV_I);
  localparam int unsigned CH_W = DATA_W / 3;

  logic [CNT_W-1:0]  cap_x;      // pixel_x aligned with the capture enable
  logic [CNT_W-1:0]  bar_full;
  logic [2:0]        bar_idx;
  logic              bar_r, bar_g, bar_b;
  logic [DATA_W-1:0] bar_rgb;

  // pixel_x must be delayed by the same REQ_LEAD-1 clocks as the capture enable.
  if (REQ_LEAD > 1) begin : g_x_pipe
    logic [REQ_LEAD-2:0][CNT_W-1:0] x_q;
    logic [REQ_LEAD-1:0][CNT_W-1:0] x_tap;

    assign x_tap = {x_q, pixel_x};
    assign cap_x = x_tap[REQ_LEAD-1];

    always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
        x_q <= '0;
      end else begin
        x_q <= x_tap[REQ_LEAD-2:0];
      end
    end
  end else begin : g_x_direct
    assign cap_x = pixel_x;
  end

  assign bar_full = cap_x / BAR_DIV;
  assign bar_idx  = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps each channel
  // directly onto an inverted bit of the bar index.
  assign bar_r   = ~bar_idx[1];
  assign bar_g   = ~bar_idx[2];
  assign bar_b   = ~bar_idx[0];
  assign bar_rgb = DATA_W'({{CH_W{bar_r}}, {CH_W{bar_g}}, {CH_W{bar_b}}});

  assign cap_data = test_mode ? bar_rgb : rgb_data;
`else
  assign cap_data = rgb_data;
`endif

  // Data returned for a request at clock t arrives during t+REQ_LEAD-1, which is exactly when
  // tap REQ_LEAD-1 of the de chain is high.
  assign rgb_d = de_tap[REQ_LEAD-1] ? cap_data : '0;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      de_q    <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_tap[REQ_LEAD-1:0];
      vs_q    <= vs_tap[REQ_LEAD-1:0];
      de_q    <= de_tap[REQ_LEAD-1:0];
      rgb_q   <= rgb_d;
    end
  end

  // XNOR with the polarity: asserted drives POL, deasserted (and reset) drives !POL.
  assign h_sync   = ~(hs_tap[REQ_LEAD] ^ HS_POL);
  assign v_sync   = ~(vs_tap[REQ_LEAD] ^ VS_POL);
  assign pixel_de = de_tap[REQ_LEAD];
  assign rgb_out  = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic rst_n;
  logic en;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic tm;
`endif

  always #5 vga_clk = ~vga_clk;

  // dut_a: REQ_LEAD=1, active-high syncs, data returned combinationally.
  // dut_b: REQ_LEAD=3, active-low syncs, data returned with 2 clocks of latency.
  logic        req_a, fs_a, run_a, hs_a, vs_a, de_a;
  logic [11:0] px_a, py_a;
  logic [23:0] rgb_in_a, rgb_a;
  logic        req_b, fs_b, run_b, hs_b, vs_b, de_b;
  logic [11:0] px_b, py_b;
  logic [23:0] rgb_in_b, rgb_b;
  logic [23:0] lat1_b = '0;
  logic [23:0] lat2_b = '0;

  assign rgb_in_a = {py_a, px_a};
  assign rgb_in_b = lat2_b;

  always @(posedge vga_clk) begin
    lat1_b <= {py_b, px_b};
    lat2_b <= lat1_b;
  end

  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(24), .REQ_LEAD(1), .CNT_W(12)
  ) dut_a (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .rgb_data(rgb_in_a),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .pixel_req(req_a), .pixel_x(px_a), .pixel_y(py_a), .frame_start(fs_a),
    .running(run_a), .h_sync(hs_a), .v_sync(vs_a), .pixel_de(de_a), .rgb_out(rgb_a)
  );

  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(24), .REQ_LEAD(3), .CNT_W(12)
  ) dut_b (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .rgb_data(rgb_in_b),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .pixel_req(req_b), .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b),
    .running(run_b), .h_sync(hs_b), .v_sync(vs_b), .pixel_de(de_b), .rgb_out(rgb_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  int k        = 0;  // clocks since the first RUN edge

  typedef struct {
    int          k;
    logic        fs, run, req;
    logic [11:0] px, py;
    logic        hs_a, vs_a, de_a;
    logic [23:0] rgb_a;
    logic        hs_b, vs_b, de_b;
    logic [23:0] rgb_b;
  } vec_t;

  vec_t tbl [16];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got %0b expected %0b", name, k, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    k++;
  endtask

  task automatic chk_vec(input int i);
    chk1("frame_start", fs_a, tbl[i].fs);
    chk1("running", run_a, tbl[i].run);
    chk1("pixel_req", req_a, tbl[i].req);
    chkw("pixel_x", 32'(px_a), 32'(tbl[i].px));
    chkw("pixel_y", 32'(py_a), 32'(tbl[i].py));
    chk1("h_sync_a", hs_a, tbl[i].hs_a);
    chk1("v_sync_a", vs_a, tbl[i].vs_a);
    chk1("pixel_de_a", de_a, tbl[i].de_a);
    chkw("rgb_out_a", 32'(rgb_a), 32'(tbl[i].rgb_a));
    chk1("h_sync_b", hs_b, tbl[i].hs_b);
    chk1("v_sync_b", vs_b, tbl[i].vs_b);
    chk1("pixel_de_b", de_b, tbl[i].de_b);
    chkw("rgb_out_b", 32'(rgb_b), 32'(tbl[i].rgb_b));
    chk1("pixel_req_b", req_b, tbl[i].req);
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_req"}, req_a, 1'b0);
    chkw({tag, "_px"}, 32'(px_a), 32'd0);
    chkw({tag, "_py"}, 32'(py_a), 32'd0);
    chk1({tag, "_fs"}, fs_a, 1'b0);
    chk1({tag, "_run"}, run_a, 1'b0);
    chk1({tag, "_hs_a"}, hs_a, 1'b0);
    chk1({tag, "_vs_a"}, vs_a, 1'b0);
    chk1({tag, "_de_a"}, de_a, 1'b0);
    chkw({tag, "_rgb_a"}, 32'(rgb_a), 32'd0);
    chk1({tag, "_hs_b"}, hs_b, 1'b1);
    chk1({tag, "_vs_b"}, vs_b, 1'b1);
    chk1({tag, "_de_b"}, de_b, 1'b0);
    chkw({tag, "_rgb_b"}, 32'(rgb_b), 32'd0);
  endtask

  initial begin
    int cnt_hs, cnt_vs, cnt_de, cnt_fs, rises, bad_gap, last_rise, low;
    logic prev_hs;
    logic [23:0] bars [8];

    //        k   fs run req px     py     hs_a vs_a de_a rgb_a        hs_b vs_b de_b rgb_b
    tbl[0]  = '{0,   1, 1, 0, 12'd0, 12'd0, 0, 0, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[1]  = '{1,   0, 1, 0, 12'd0, 12'd0, 1, 1, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[2]  = '{3,   0, 1, 0, 12'd0, 12'd0, 0, 1, 0, 24'h000000, 0, 0, 0, 24'h000000};
    tbl[3]  = '{5,   0, 1, 0, 12'd0, 12'd0, 0, 1, 0, 24'h000000, 1, 0, 0, 24'h000000};
    tbl[4]  = '{15,  0, 1, 0, 12'd0, 12'd0, 1, 0, 0, 24'h000000, 1, 0, 0, 24'h000000};
    tbl[5]  = '{17,  0, 1, 0, 12'd0, 12'd0, 0, 0, 0, 24'h000000, 0, 1, 0, 24'h000000};
    tbl[6]  = '{32,  0, 1, 1, 12'd0, 12'd0, 0, 0, 0, 24'h000000, 0, 1, 0, 24'h000000};
    tbl[7]  = '{34,  0, 1, 1, 12'd2, 12'd0, 0, 0, 1, 24'h000001, 1, 1, 0, 24'h000000};
    tbl[8]  = '{36,  0, 1, 1, 12'd4, 12'd0, 0, 0, 1, 24'h000003, 1, 1, 1, 24'h000001};
    tbl[9]  = '{40,  0, 1, 0, 12'd0, 12'd0, 0, 0, 1, 24'h000007, 1, 1, 1, 24'h000005};
    tbl[10] = '{43,  0, 1, 0, 12'd0, 12'd0, 1, 0, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[11] = '{80,  0, 1, 1, 12'd6, 12'd3, 0, 0, 1, 24'h003005, 1, 1, 1, 24'h003003};
    tbl[12] = '{86,  0, 1, 0, 12'd0, 12'd0, 1, 0, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[13] = '{98,  1, 1, 0, 12'd0, 12'd0, 0, 0, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[14] = '{99,  0, 1, 0, 12'd0, 12'd0, 1, 1, 0, 24'h000000, 1, 1, 0, 24'h000000};
    tbl[15] = '{101, 0, 1, 0, 12'd0, 12'd0, 0, 1, 0, 24'h000000, 0, 0, 0, 24'h000000};

    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    rst_n = 1'b0;
    en    = 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    tm    = 1'b0;
`endif
    repeat (3) @(posedge vga_clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge vga_clk);
    #1;
    chk_idle("idle_en0");

    // Two full frames with en held high, table vectors plus period counts.
    en = 1'b1;
    @(posedge vga_clk);
    #1;
    k = 0;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;
    rises = 0; bad_gap = 0; last_rise = -1; prev_hs = 1'b0;
    for (int c = 0; c <= 196; c++) begin
      if (c > 0) step();
      for (int i = 0; i < 16; i++) begin
        if (tbl[i].k == k) chk_vec(i);
      end
      if (k >= 1) begin
        cnt_hs += int'(hs_a);
        cnt_vs += int'(vs_a);
        cnt_de += int'(de_a);
      end
      if (k <= 195) cnt_fs += int'(fs_a);
      if (hs_a && !prev_hs) begin
        if (last_rise >= 0 && (k - last_rise) != 14) bad_gap++;
        last_rise = k;
        rises++;
      end
      prev_hs = hs_a;
    end
    chkw("hs_high_clocks", 32'(cnt_hs), 32'd28);
    chkw("hs_rises", 32'(rises), 32'd14);
    chkw("hs_period_errors", 32'(bad_gap), 32'd0);
    chkw("vs_high_clocks", 32'(cnt_vs), 32'd28);
    chkw("de_clocks_2frames", 32'(cnt_de), 32'd64);
    chkw("frame_starts", 32'(cnt_fs), 32'd2);
    chk1("frame_start_196", fs_a, 1'b1);

    // Frame 3: en dropped at v=2 then raised again before the frame ends.
    cnt_fs = 0; low = 0; cnt_de = 0;
    while (k < 294) begin
      if (k == 224) en = 1'b0;
      if (k == 230) en = 1'b1;
      step();
      if (k < 294) begin
        cnt_fs += int'(fs_a);
        low    += int'(!run_a);
      end
      cnt_de += int'(de_a);
      if (k == 227) chk1("stop_pend_running", run_a, 1'b1);
    end
    chkw("resume_extra_fs", 32'(cnt_fs), 32'd0);
    chkw("resume_run_gap", 32'(low), 32'd0);
    chkw("resume_de_clocks", 32'(cnt_de), 32'd32);
    chk1("resume_next_fs", fs_a, 1'b1);

    // Frame 4: en dropped and held low; the frame completes, then idle.
    cnt_de = 0;
    while (k < 392) begin
      if (k == 300) en = 1'b0;
      step();
      cnt_de += int'(de_a);
      if (k == 391) chk1("stop_running_last", run_a, 1'b1);
    end
    chk1("stop_running_fall", run_a, 1'b0);
    chk1("stop_no_fs", fs_a, 1'b0);
    chkw("stop_de_clocks", 32'(cnt_de), 32'd32);
    while (k < 397) step();
    chk_idle("after_stop");

    // Restart, optional bar pattern, then a synchronous reset at v=3, h=5.
    while (k < 400) step();
    en = 1'b1;
    step();
    chk1("restart_fs", fs_a, 1'b1);
    chk1("restart_run", run_a, 1'b1);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    tm = 1'b1;
    while (k < 441) begin
      step();
      if (k >= 434) begin
        chk1("bar_de", de_a, 1'b1);
        chkw("bar_rgb", 32'(rgb_a), 32'(bars[k-434]));
      end
    end
    tm = 1'b0;
`endif
    while (k < 448) step();
    chk1("pre_reset_req", req_a, 1'b1);
    chkw("pre_reset_px", 32'(px_a), 32'd1);
    chkw("pre_reset_py", 32'(py_a), 32'd1);
    chk1("pre_reset_de", de_a, 1'b1);
    rst_n = 1'b0;
    step();
    chk_idle("sync_reset");
    rst_n = 1'b1;
    step();
    chk1("post_reset_fs", fs_a, 1'b1);
    chk1("post_reset_run", run_a, 1'b1);
    chk1("post_reset_de", de_a, 1'b0);
    step();
    chk1("post_reset_hs", hs_a, 1'b1);
    chk1("post_reset_vs", vs_a, 1'b1);
    while (k < 483) step();
    chk1("post_reset_req", req_a, 1'b1);
    chkw("post_reset_px", 32'(px_a), 32'd1);
    chkw("post_reset_py", 32'(py_a), 32'd0);

    // en falls on the same edge as the frame wrap: one more full frame is generated.
    while (k < 547) step();
    en = 1'b0;
    step();
    chk1("wrap_stop_fs", fs_a, 1'b1);
    chk1("wrap_stop_run", run_a, 1'b1);
    while (k < 645) step();
    chk1("wrap_stop_last", run_a, 1'b1);
    step();
    chk1("wrap_stop_fall", run_a, 1'b0);
    chk1("wrap_stop_fall_b", run_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
